// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, LCR/FIFO-status types and reset values
// shared by uart_apb_regs and uart_irq_gen.
package uart_pkg;

  localparam logic [2:0] OFF_TBR = 3'd0;
  localparam logic [2:0] OFF_LCR = 3'd1;
  localparam logic [2:0] OFF_DLL = 3'd2;
  localparam logic [2:0] OFF_DLH = 3'd3;
  localparam logic [2:0] OFF_IER = 3'd4;
  localparam logic [2:0] OFF_FSR = 3'd5;

  localparam int LCR_WLS = 0;
  localparam int LCR_STB = 2;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;
  localparam int LCR_BGE = 5;
  localparam int LCR_OSM = 6;

  typedef struct packed {
    logic       osm_sel;
    logic       bge;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  // Shared layout for IER enables and FSR status bits.
  typedef struct packed {
    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;
  } fifo_bits_t;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } apb_st_e;

  localparam lcr_t       LCR_RST = lcr_t'(7'b000_0011);
  localparam logic [7:0] DLL_RST = 8'd27;
  localparam logic [7:0] DLH_RST = 8'd0;
  localparam fifo_bits_t IER_RST = fifo_bits_t'(4'b0000);

  function automatic logic [31:0] fsr_word(fifo_bits_t s);
    return {28'd0, s};
  endfunction

endpackage

// File: rtl/uart_apb_regs_if.sv
// uart_apb_regs_if: APB3 bus bundle between the SoC master
// and the UART register bank.
interface uart_apb_regs_if #(
  parameter int ADDR_W = 12
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_irq_gen.sv
// uart_irq_gen: level interrupt from enabled FIFO status bits,
// registered one cycle behind its inputs.
module uart_irq_gen
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  fifo_bits_t ier,
  input  fifo_bits_t status,
  output logic       irq
);

  // Any enabled status condition raises irq on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(ier & status);
    end
  end

endmodule

// File: rtl/uart_apb_regs.sv
// uart_apb_regs: APB3 register bank driving UART_IP configuration
// and FIFO strobes. Build option UART_APB_IRQ_EN adds IER and irq.
module uart_apb_regs
  import uart_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  uart_apb_regs_if.slave apb,
  output logic [7:0] TBR_i,
  output logic       tx_flag,
  output logic       rx_flag,
  input  logic [7:0] RBR_o,
  input  logic       tx_fifo_empty,
  input  logic       tx_fifo_full,
  input  logic       rx_fifo_empty,
  input  logic       rx_fifo_full,
  output logic [1:0] WLS,
  output logic       STB,
  output logic       PEN,
  output logic       EPS,
  output logic       BGE,
  output logic       OSM_SEL,
  output logic [7:0] DLL,
  output logic [7:0] DLH,
  output logic       en_tx_fifo_empty,
  output logic       en_tx_fifo_full,
  output logic       en_rx_fifo_empty,
  output logic       en_rx_fifo_full,
  output logic       irq
);

  apb_st_e    state;
  lcr_t       lcr_q;
  logic [7:0] dll_q;
  logic [7:0] dlh_q;
  fifo_bits_t ier_q;
  fifo_bits_t stat;

  logic [31:0] prdata_q;
  logic        pslverr_q;

  logic [2:0]  off;
  logic        hi_bad;
  logic        addr_bad;
  logic        setup;

  logic        err;
  logic        push;
  logic        pop;
  logic        wr_lcr;
  logic        wr_dll;
  logic        wr_dlh;
  logic        wr_ier;
  logic [31:0] rdata;

  logic unused_bits;

  assign stat = '{
    rx_full:  rx_fifo_full,
    rx_empty: rx_fifo_empty,
    tx_full:  tx_fifo_full,
    tx_empty: tx_fifo_empty
  };

  assign off      = apb.PADDR[4:2];
  assign hi_bad   = |apb.PADDR[ADDR_W-1:5];
  assign addr_bad = hi_bad || (off > OFF_FSR);
  assign setup    = (state == S_IDLE)
                  && apb.PSEL
                  && !apb.PENABLE;

  // Decode the current bus request into actions and read data.
  always_comb begin
    err    = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    wr_lcr = 1'b0;
    wr_dll = 1'b0;
    wr_dlh = 1'b0;
    wr_ier = 1'b0;
    rdata  = '0;
    unique case (1'b1)
      addr_bad: begin
        err = 1'b1;
      end
      (!addr_bad && apb.PWRITE): begin
        unique case (off)
          OFF_TBR: begin
            err  = tx_fifo_full;
            push = !tx_fifo_full;
          end
          OFF_LCR: wr_lcr = 1'b1;
          OFF_DLL: wr_dll = 1'b1;
          OFF_DLH: wr_dlh = 1'b1;
          OFF_IER: wr_ier = 1'b1;
          default: err = 1'b1;
        endcase
      end
      default: begin
        unique case (off)
          OFF_TBR: begin
            err   = rx_fifo_empty;
            pop   = !rx_fifo_empty;
            rdata = rx_fifo_empty ? 32'd0 : {24'd0, RBR_o};
          end
          OFF_LCR: rdata = {25'd0, lcr_q};
          OFF_DLL: rdata = {24'd0, dll_q};
          OFF_DLH: rdata = {24'd0, dlh_q};
          OFF_IER: rdata = {28'd0, ier_q};
          default: rdata = fsr_word(stat);
        endcase
      end
    endcase
  end

  // Transfer FSM: commit everything on the setup edge, hold for access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      tx_flag   <= 1'b0;
      rx_flag   <= 1'b0;
      TBR_i     <= '0;
      lcr_q     <= LCR_RST;
      dll_q     <= DLL_RST;
      dlh_q     <= DLH_RST;
    end else begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      tx_flag   <= 1'b0;
      rx_flag   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (setup) begin
            state     <= S_ACCESS;
            prdata_q  <= rdata;
            pslverr_q <= err;
            tx_flag   <= push;
            rx_flag   <= pop;
            if (push) TBR_i <= apb.PWDATA[7:0];
            if (wr_lcr) begin
              lcr_q <= lcr_t'(apb.PWDATA[LCR_OSM:LCR_WLS]);
            end
            if (wr_dll) dll_q <= apb.PWDATA[7:0];
            if (wr_dlh) dlh_q <= apb.PWDATA[7:0];
          end
        end
        S_ACCESS: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_APB_IRQ_EN
  // Interrupt-enable register, written on the setup edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ier_q <= IER_RST;
    end else if (setup && wr_ier) begin
      ier_q <= fifo_bits_t'(apb.PWDATA[3:0]);
    end
  end

  uart_irq_gen u_irq (
    .clk    (clk),
    .rst    (rst),
    .ier    (ier_q),
    .status (stat),
    .irq    (irq)
  );
`else
  logic unused_ier;

  assign ier_q      = IER_RST;
  assign irq        = 1'b0;
  assign unused_ier = wr_ier;
`endif

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = pslverr_q;

  assign WLS     = lcr_q.wls;
  assign STB     = lcr_q[LCR_STB];
  assign PEN     = lcr_q[LCR_PEN];
  assign EPS     = lcr_q[LCR_EPS];
  assign BGE     = lcr_q[LCR_BGE];
  assign OSM_SEL = lcr_q.osm_sel;
  assign DLL     = dll_q;
  assign DLH     = dlh_q;

  assign en_tx_fifo_empty = ier_q.tx_empty;
  assign en_tx_fifo_full  = ier_q.tx_full;
  assign en_rx_fifo_empty = ier_q.rx_empty;
  assign en_rx_fifo_full  = ier_q.rx_full;

  assign unused_bits = ^{apb.PWDATA[31:8], apb.PADDR[1:0]};

endmodule

// File: tb/tb_uart_apb_regs.sv
// tb_uart_apb_regs: directed and random APB traffic against a
// register/FIFO reference model; honours UART_APB_IRQ_EN.
module tb_uart_apb_regs;

  localparam int TXD = 4;
  localparam int RXD = 4;

`ifdef UART_APB_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_apb_regs_if #(.ADDR_W(12)) apb();

  logic [7:0] TBR_i, RBR_o, DLL, DLH;
  logic       tx_flag, rx_flag;
  logic       tx_fifo_empty, tx_fifo_full;
  logic       rx_fifo_empty, rx_fifo_full;
  logic [1:0] WLS;
  logic       STB, PEN, EPS, BGE, OSM_SEL;
  logic       en_tx_fifo_empty, en_tx_fifo_full;
  logic       en_rx_fifo_empty, en_rx_fifo_full;
  logic       irq;

  uart_apb_regs #(.ADDR_W(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .apb              (apb),
    .TBR_i            (TBR_i),
    .tx_flag          (tx_flag),
    .rx_flag          (rx_flag),
    .RBR_o            (RBR_o),
    .tx_fifo_empty    (tx_fifo_empty),
    .tx_fifo_full     (tx_fifo_full),
    .rx_fifo_empty    (rx_fifo_empty),
    .rx_fifo_full     (rx_fifo_full),
    .WLS              (WLS),
    .STB              (STB),
    .PEN              (PEN),
    .EPS              (EPS),
    .BGE              (BGE),
    .OSM_SEL          (OSM_SEL),
    .DLL              (DLL),
    .DLH              (DLH),
    .en_tx_fifo_empty (en_tx_fifo_empty),
    .en_tx_fifo_full  (en_tx_fifo_full),
    .en_rx_fifo_empty (en_rx_fifo_empty),
    .en_rx_fifo_full  (en_rx_fifo_full),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [6:0] m_lcr;
  logic [7:0] m_dll, m_dlh, m_tbr;
  logic [3:0] m_ier;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void upd_status();
    tx_fifo_empty = (txq.size() == 0);
    tx_fifo_full  = (txq.size() == TXD);
    rx_fifo_empty = (rxq.size() == 0);
    rx_fifo_full  = (rxq.size() == RXD);
    RBR_o         = (rxq.size() != 0) ? rxq[0] : 8'hEE;
  endfunction

  function automatic void model_reset();
    m_lcr = 7'h03;
    m_dll = 8'd27;
    m_dlh = 8'd0;
    m_ier = 4'd0;
    m_tbr = 8'd0;
  endfunction

  function automatic logic [3:0] fsr_now();
    return {rx_fifo_full, rx_fifo_empty, tx_fifo_full, tx_fifo_empty};
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".lcr"}, {OSM_SEL, BGE, EPS, PEN, STB, WLS}, m_lcr);
    chk({tag, ".dll"}, DLL, m_dll);
    chk({tag, ".dlh"}, DLH, m_dlh);
    chk({tag, ".en"},
        {en_rx_fifo_full, en_rx_fifo_empty,
         en_tx_fifo_full, en_tx_fifo_empty},
        IRQ_EN ? m_ier : 4'd0);
    chk({tag, ".tbr"}, TBR_i, m_tbr);
  endtask

  // One full APB transfer plus a trailing idle cycle, fully checked.
  // Called at #1 after a rising edge.
  task automatic xfer(input bit wr, input logic [11:0] addr,
                      input logic [31:0] wd, input string tag);
    int          off;
    bit          bad, e_err, e_tx, e_rx;
    logic [31:0] e_rd;
    logic [3:0]  e_irq;
    off   = int'(addr[4:2]);
    bad   = (addr[11:5] != 0) || (off > 5);
    e_err = 0;
    e_tx  = 0;
    e_rx  = 0;
    e_rd  = 0;
    if (bad) begin
      e_err = 1;
    end else if (wr) begin
      case (off)
        0: begin
          if (tx_fifo_full) e_err = 1;
          else begin e_tx = 1; m_tbr = wd[7:0]; end
        end
        1: m_lcr = wd[6:0];
        2: m_dll = wd[7:0];
        3: m_dlh = wd[7:0];
        4: m_ier = IRQ_EN ? wd[3:0] : 4'd0;
        default: e_err = 1;
      endcase
    end else begin
      case (off)
        0: begin
          if (rx_fifo_empty) e_err = 1;
          else begin e_rx = 1; e_rd = {24'd0, RBR_o}; end
        end
        1: e_rd = {25'd0, m_lcr};
        2: e_rd = {24'd0, m_dll};
        3: e_rd = {24'd0, m_dlh};
        4: e_rd = {28'd0, m_ier};
        default: e_rd = {28'd0, fsr_now()};
      endcase
    end
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PWDATA  = wd;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    chk({tag, ".prdata"}, apb.PRDATA, e_rd);
    chk({tag, ".pslverr"}, apb.PSLVERR, e_err);
    chk({tag, ".pready"}, apb.PREADY, 1'b1);
    chk({tag, ".tx_flag"}, tx_flag, e_tx);
    chk({tag, ".rx_flag"}, rx_flag, e_rx);
    check_regs(tag);
    @(posedge clk); #1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWDATA  = $urandom();
    if (e_tx) txq.push_back(wd[7:0]);
    if (e_rx) void'(rxq.pop_front());
    upd_status();
    chk({tag, ".tx_flag_end"}, tx_flag, 1'b0);
    chk({tag, ".rx_flag_end"}, rx_flag, 1'b0);
    @(posedge clk); #1;
    e_irq = m_ier & fsr_now();
    chk({tag, ".irq"}, irq, IRQ_EN ? |e_irq : 1'b0);
  endtask

  initial begin
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    model_reset();
    upd_status();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.prdata", apb.PRDATA, 32'd0);
    chk("rst.pslverr", apb.PSLVERR, 1'b0);
    chk("rst.tx_flag", tx_flag, 1'b0);
    chk("rst.rx_flag", rx_flag, 1'b0);
    chk("rst.irq", irq, 1'b0);
    check_regs("rst");
    rst = 1'b0;

    xfer(0, 12'h004, 0, "rd_lcr");
    xfer(0, 12'h008, 0, "rd_dll");
    xfer(0, 12'h00C, 0, "rd_dlh");

    xfer(1, 12'h004, 32'h0000_003A, "wr_lcr");
    chk("lcr_fields", {OSM_SEL, BGE, EPS, PEN, STB, WLS}, 7'b0111010);

    xfer(1, 12'h000, 32'h0000_00A5, "push");
    chk("push_tbr", TBR_i, 8'hA5);
    while (txq.size() < TXD) txq.push_back(8'h00);
    upd_status();
    xfer(1, 12'h000, 32'h0000_003C, "push_full");

    rxq.push_back(8'h5C);
    upd_status();
    xfer(0, 12'h000, 0, "pop");
    xfer(0, 12'h000, 0, "pop_empty");

    xfer(0, 12'h018, 0, "rd_0x18");
    xfer(1, 12'h014, 32'hFFFF_FFFF, "wr_fsr");
    xfer(1, 12'h104, 32'h0000_0055, "wr_upper");
    xfer(0, 12'h014, 0, "rd_fsr");

    txq.delete();
    upd_status();
    xfer(1, 12'h010, 32'h1, "ier_set");
    xfer(0, 12'h010, 0, "rd_ier");
    xfer(1, 12'h010, 32'h0, "ier_clr");

    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b1;
    apb.PWRITE  = 1'b1;
    apb.PADDR   = 12'h000;
    apb.PWDATA  = 32'h11;
    @(posedge clk); #1;
    chk("noset.tx_flag", tx_flag, 1'b0);
    chk("noset.pslverr", apb.PSLVERR, 1'b0);
    apb.PADDR  = 12'h004;
    apb.PWDATA = 32'h7F;
    @(posedge clk); #1;
    check_regs("noset");
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    @(posedge clk); #1;

    xfer(1, 12'h004, 32'h15, "pre_rst");
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b1;
    apb.PADDR   = 12'h000;
    apb.PWDATA  = 32'h77;
    rst         = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("midrst.tx_flag", tx_flag, 1'b0);
    chk("midrst.pslverr", apb.PSLVERR, 1'b0);
    check_regs("midrst");
    rst      = 1'b0;
    apb.PSEL = 1'b0;
    @(posedge clk); #1;
    chk("midrst.tx_flag2", tx_flag, 1'b0);
    chk("midrst.irq", irq, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [11:0] a;
      a = 12'({$urandom_range(0, 7), 2'($urandom_range(0, 3))});
      if ($urandom_range(0, 15) == 0) a[11:5] = 7'($urandom_range(1, 127));
      if ($urandom_range(0, 7) == 0 && txq.size() != 0) void'(txq.pop_front());
      if ($urandom_range(0, 2) == 0 && rxq.size() < RXD) rxq.push_back(8'($urandom()));
      upd_status();
      xfer(1'($urandom_range(0, 1)), a, $urandom(), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_apb_regs.md
# uart_apb_regs

APB3 slave register bank sitting directly upstream of `UART_IP`: it owns the line-control, divisor and interrupt-enable registers and drives `UART_IP`'s configuration inputs. It converts APB writes into single-cycle `tx_flag` pushes and APB reads into single-cycle `rx_flag` pops. It also exposes FIFO status and an optional level interrupt to the SoC bus.

## Interface
- `ADDR_W`, 12, APB address width (byte addressing; only `PADDR[4:2]` decoded, upper bits must be 0)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `PSEL`, `PENABLE`, `PWRITE`  in  1 each  APB3 controls
- `PADDR`  in  ADDR_W  byte address
- `PWDATA`  in  32  write data
- `PRDATA`  out  32  read data, registered
- `PREADY`  out  1  tied 1 (zero wait states)
- `PSLVERR`  out  1  error response, registered
- `TBR_i`  out  8  byte to TX FIFO
- `tx_flag`  out  1  TX FIFO push strobe
- `rx_flag`  out  1  RX FIFO pop strobe
- `RBR_o`  in  8  RX FIFO head (show-ahead)
- `tx_fifo_empty`, `tx_fifo_full`, `rx_fifo_empty`, `rx_fifo_full`  in  1 each  FIFO status
- `WLS`  out  2;  `STB`, `PEN`, `EPS`, `BGE`, `OSM_SEL`  out  1 each  line control
- `DLL`, `DLH`  out  8 each  baud divisor
- `en_tx_fifo_empty`, `en_tx_fifo_full`, `en_rx_fifo_empty`, `en_rx_fifo_full`  out  1 each  interrupt enables
- `irq`  out  1  level interrupt

## Operation
- Register map (offset, access, fields):
  - 0x00 TBR/RBR: W = push `PWDATA[7:0]`; R = pop, `PRDATA[7:0]` = `RBR_o`
  - 0x04 LCR RW: `[1:0]` WLS, `[2]` STB, `[3]` PEN, `[4]` EPS, `[5]` BGE, `[6]` OSM_SEL
  - 0x08 DLL RW `[7:0]`; 0x0C DLH RW `[7:0]`
  - 0x10 IER RW: `[0]` tx_empty, `[1]` tx_full, `[2]` rx_empty, `[3]` rx_full
  - 0x14 FSR RO: `[0]` tx_fifo_empty, `[1]` tx_fifo_full, `[2]` rx_fifo_empty, `[3]` rx_fifo_full
- Unused read bits return 0.
- Two-state FSM: IDLE → ACCESS on `PSEL & !PENABLE` (setup). ACCESS → IDLE unconditionally next cycle, since PREADY=1.
- All decisions are made on the setup edge and registered: PRDATA, PSLVERR, `tx_flag`/`TBR_i`, `rx_flag`, register writes.
- PSLVERR=1 conditions:
  - write to 0x00 while `tx_fifo_full`: no push
  - read of 0x00 while `rx_fifo_empty`: no pop, PRDATA=0
  - write to FSR
  - any offset ≥ 0x18 or nonzero upper address bits
- On error, registers are unchanged.
- `PENABLE` high without a preceding setup is ignored: no side effects.
- Reset values: LCR = WLS 2'b11, all other bits 0; DLL=8'd27, DLH=0; IER=0; PRDATA=0; PSLVERR=0; `tx_flag`=`rx_flag`=0; `TBR_i`=0; `irq`=0.
- Reset mid-transfer: FSM returns to IDLE and any pending strobe is dropped the same edge.

## Timing
- Setup cycle N: inputs sampled at edge ending N.
- Cycle N+1 (access): PRDATA/PSLVERR valid; `tx_flag` or `rx_flag` high for exactly this cycle. The FIFO acts at edge ending N+1.
- RBR read returns the pre-pop head. Back-to-back transfers (setup at N+2) see updated FIFO flags.
- Register writes are visible on outputs from cycle N+1.
- `irq` is registered: rises 1 cycle after an enabled status bit and its IER bit are both 1.

## Configuration
- `UART_APB_IRQ_EN` defined: IER implemented; `en_*` outputs mirror IER; `irq` = registered OR of enabled status conditions.
- Undefined: IER reads 0 and writes are accepted without error; `en_*` tied 0; `irq` tied 0.

## Structure
- `uart_pkg`: register offset localparams, LCR bit-index constants, LCR/IER packed-struct typedefs, reset constants.
- One sub-module `uart_irq_gen`: IER & status → registered `irq`. Instantiated only under `UART_APB_IRQ_EN`.

## Test plan
- Reset, then read 0x04/0x08/0x0C → 0x03 / 27 / 0, PSLVERR=0.
- Write 0x04 = 0x3A → WLS=2'b10, PEN=1, EPS=1, BGE=1, STB=0, OSM_SEL=0 visible on the access cycle.
- Write 0x00 = 0xA5 with `tx_fifo_full`=0 → `TBR_i`=0xA5 and `tx_flag`=1 for exactly one cycle. Repeat with full=1 → PSLVERR=1, no strobe.
- `RBR_o`=0x5C, `rx_fifo_empty`=0, read 0x00 → PRDATA=0x5C, one `rx_flag` pulse. With empty=1 → PRDATA=0, PSLVERR=1, no pulse.
- Read 0x18 and write 0x14 → PSLVERR=1, no register change.
- With macro: IER=0x1 and `tx_fifo_empty`=1 → `irq`=1 one cycle later. Clear IER → `irq`=0. Without macro: `irq` stays 0.
